// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operand sequencer: opcodes, FSM states and
// instruction field positions.
package alu_seq_pkg;

  localparam int DATA_W   = 4;
  localparam int RF_DEPTH = 4;
  localparam int IDX_W    = 2;
  localparam int INSTR_W  = 11;

  // Opcodes are forwarded to the ALU unchanged.
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_SHL = 2'b10;
  localparam logic [1:0] OP_SHR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Instruction field positions. imm overlaps rs2 and is only meaningful for LD.
  localparam int LD_BIT  = 10;
  localparam int OP_MSB  = 9;
  localparam int OP_LSB  = 8;
  localparam int RD_MSB  = 7;
  localparam int RD_LSB  = 6;
  localparam int RS1_MSB = 5;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 2;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

endpackage

// File: rtl/alu_seq_regfile.sv
// Small register file: two combinational read ports, one synchronous write
// port, every entry cleared by the asynchronous reset.
module alu_seq_regfile #(
  parameter int NREG = 4,
  parameter int W    = 4,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr1,
  input  logic [AW-1:0] i_raddr2,
  output logic [W-1:0]  o_rdata1,
  output logic [W-1:0]  o_rdata2
);

  logic [W-1:0] r_rf [NREG];

  // Write port; reset clears all entries.
  // NOTE: this array is deliberately reset -- an aborted instruction must leave
  // a zeroed file behind -- so it maps to flops, not a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_rf[i] <= '0;
      end
    end else if (i_we) begin
      r_rf[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = r_rf[i_raddr1];
  assign o_rdata2 = r_rf[i_raddr2];

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one instruction at a time to an external 4-bit ALU: reads operands
// from the register file, drives registered A/B/ctrl, captures Z, writes it
// back and offers it downstream with zero/negative flags.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NREG = 4,
  parameter int W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic [W-1:0]       alu_a,
  output logic [W-1:0]       alu_b,
  output logic [1:0]         alu_ctrl,
  input  logic [W-1:0]       alu_z,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_data,
  output logic [IDX_W-1:0]   out_rd,
  output logic               out_zero,
  output logic               out_neg
);

  state_t           r_state;
  logic [W-1:0]     r_alu_a;
  logic [W-1:0]     r_alu_b;
  logic [1:0]       r_alu_ctrl;
  logic [IDX_W-1:0] r_rd;
  logic             r_out_valid;
  logic [W-1:0]     r_out_data;
  logic [IDX_W-1:0] r_out_rd;
  logic             r_out_zero;
  logic             r_out_neg;

  logic             w_accept;
  logic             w_ld;
  logic [1:0]       w_op;
  logic [IDX_W-1:0] w_rd;
  logic [IDX_W-1:0] w_rs1;
  logic [IDX_W-1:0] w_rs2;
  logic [W-1:0]     w_imm;
  logic [W-1:0]     w_rdata1;
  logic [W-1:0]     w_rdata2;
  logic             w_we;
  logic [IDX_W-1:0] w_waddr;
  logic [W-1:0]     w_wdata;

  // Instruction field decode.
  assign w_ld  = in_instr[LD_BIT];
  assign w_op  = in_instr[OP_MSB:OP_LSB];
  assign w_rd  = in_instr[RD_MSB:RD_LSB];
  assign w_rs1 = in_instr[RS1_MSB:RS1_LSB];
  assign w_rs2 = in_instr[RS2_MSB:RS2_LSB];
  assign w_imm = in_instr[IMM_MSB:IMM_LSB];

  // Ready is gated by reset so nothing is accepted while the block is held.
  assign in_ready = rst_n & (r_state == S_IDLE);
  assign w_accept = in_valid & in_ready;

  alu_seq_regfile #(
    .NREG (NREG),
    .W    (W)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (w_we),
    .i_waddr  (w_waddr),
    .i_wdata  (w_wdata),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2)
  );

  // Write-back select: ALU result on leaving EXEC, immediate on an LD accept.
  // The same value feeds the output register so the flags match what is stored.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_rd;
    w_wdata = alu_z;
    if (r_state == S_EXEC) begin
      w_we = 1'b1;
    end else if (w_accept && w_ld) begin
      w_we    = 1'b1;
      w_waddr = w_rd;
      w_wdata = w_imm;
    end
  end

  // Control FSM with registered ALU drive and result outputs.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_ctrl  <= '0;
      r_rd        <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_rd    <= '0;
      r_out_zero  <= 1'b0;
      r_out_neg   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_ld) begin
              r_out_data  <= w_wdata;
              r_out_rd    <= w_rd;
              r_out_zero  <= (w_wdata == '0);
              r_out_neg   <= w_wdata[W-1];
              r_out_valid <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              // Operands are read before any write, so rd == rs sees the old value.
              r_alu_a    <= w_rdata1;
              r_alu_b    <= w_rdata2;
              r_alu_ctrl <= w_op;
              r_rd       <= w_rd;
              r_state    <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          r_out_data  <= w_wdata;
          r_out_rd    <= r_rd;
          r_out_zero  <= (w_wdata == '0);
          r_out_neg   <= w_wdata[W-1];
          r_out_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_ctrl  = r_alu_ctrl;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_rd    = r_out_rd;
  assign out_zero  = r_out_zero;
  assign out_neg   = r_out_neg;

endmodule
